// File: rtl/fc_backward_if.sv
// Bus bundle for fc_backward: pass control, dZ stream in, weight-memory read port, dX stream out.
// The master side is the environment; the slave side is the layer.
interface fc_backward_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 14
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 dz_valid;
  logic                 dz_ready;
  logic [WORD_SIZE-1:0] dz_data;
  logic                 w_ren;
  logic [ADDR_W-1:0]    w_addr;
  logic [WORD_SIZE-1:0] w_rdata;
  logic                 dx_valid;
  logic                 dx_ready;
  logic [WORD_SIZE-1:0] dx_data;

  modport master (
    output start, dz_valid, dz_data, w_rdata, dx_ready,
    input  busy, done, dz_ready, w_ren, w_addr, dx_valid, dx_data
  );

  modport slave (
    input  start, dz_valid, dz_data, w_rdata, dx_ready,
    output busy, done, dz_ready, w_ren, w_addr, dx_valid, dx_data
  );
endinterface

// File: rtl/fc_backward.sv
// Fully-connected backward pass: dX = W^T * dZ, one fixed-point MAC per clock.
// Weights are streamed row-major from a 1-cycle-latency memory; dX leaves as a ready/valid stream.
module fc_backward #(
  parameter int WORD_SIZE     = 16,
  parameter int IP_LAYER_SIZE = 128,
  parameter int OP_LAYER_SIZE = 84,
  parameter int INT_SLICE     = 8,
  parameter int ADDR_W        = $clog2(IP_LAYER_SIZE * OP_LAYER_SIZE)
) (
  input logic          clk,
  input logic          rst_n,
  fc_backward_if.slave bus
);
  localparam int DEC_SLICE = WORD_SIZE - INT_SLICE;
  localparam int K_W = (IP_LAYER_SIZE > 1) ? $clog2(IP_LAYER_SIZE) : 1;
  localparam int I_W = (OP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(IP_LAYER_SIZE - 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(OP_LAYER_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DZ, MAC, OUT} state_t;

  state_t                      state_q;
  logic [I_W-1:0]              i_q;
  logic [K_W-1:0]              col_q;
  logic [K_W-1:0]              k_q;
  logic [K_W-1:0]              idx_p1_q;
  logic                        vld_p1_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        dz_ready_q;
  logic                        w_ren_q;
  logic                        dx_valid_q;
  logic [ADDR_W-1:0]           w_addr_q;
  logic signed [WORD_SIZE-1:0] dz_q;
  logic signed [WORD_SIZE-1:0] acc_q [IP_LAYER_SIZE];

  logic signed [WORD_SIZE-1:0] prod_d;
  logic                        clr_d;
  logic                        dz_hs_d;

  // Q-format product truncated toward zero: scale the magnitude, then restore the sign.
  function automatic logic signed [WORD_SIZE-1:0] prod(
    input logic signed [WORD_SIZE-1:0] w,
    input logic signed [WORD_SIZE-1:0] d
  );
    logic signed [2*WORD_SIZE-1:0] p;
    logic [2*WORD_SIZE-1:0]        mag;
    logic [WORD_SIZE-1:0]          t;
    p   = $signed({{WORD_SIZE{w[WORD_SIZE-1]}}, w}) * $signed({{WORD_SIZE{d[WORD_SIZE-1]}}, d});
    mag = p[2*WORD_SIZE-1] ? $unsigned(-p) : $unsigned(p);
    t   = mag[DEC_SLICE +: WORD_SIZE];
    return p[2*WORD_SIZE-1] ? $signed(-t) : $signed(t);
  endfunction

  assign clr_d   = (state_q == IDLE) && bus.start;
  assign dz_hs_d = dz_ready_q && bus.dz_valid;
  assign prod_d  = prod(bus.w_rdata, dz_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      col_q      <= '0;
      k_q        <= '0;
      idx_p1_q   <= '0;
      vld_p1_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_ready_q <= 1'b0;
      w_ren_q    <= 1'b0;
      dx_valid_q <= 1'b0;
      w_addr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= WAIT_DZ;
            busy_q     <= 1'b1;
            dz_ready_q <= 1'b1;
            i_q        <= '0;
            w_addr_q   <= '0;
          end
        end
        WAIT_DZ: begin
          if (dz_hs_d) begin
            state_q    <= MAC;
            dz_ready_q <= 1'b0;
            w_ren_q    <= 1'b1;
            col_q      <= '0;
          end
        end
        MAC: begin
          // p0: weight read issue, p1: accumulate of the word returned by memory
          vld_p1_q <= w_ren_q;
          idx_p1_q <= col_q;
          if (w_ren_q) begin
            w_addr_q <= w_addr_q + ADDR_W'(1);
            if (col_q == K_LAST) w_ren_q <= 1'b0;
            else                 col_q   <= col_q + K_W'(1);
          end
          if (vld_p1_q && (idx_p1_q == K_LAST)) begin
            if (i_q == I_LAST) begin
              state_q    <= OUT;
              k_q        <= '0;
              dx_valid_q <= 1'b1;
            end else begin
              state_q    <= WAIT_DZ;
              i_q        <= i_q + I_W'(1);
              dz_ready_q <= 1'b1;
            end
          end
        end
        OUT: begin
          if (bus.dx_ready) begin
            if (k_q == K_LAST) begin
              state_q    <= IDLE;
              dx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              k_q <= k_q + K_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; a new pass clears the accumulators on start.
  always_ff @(posedge clk) begin
    if (dz_hs_d) dz_q <= bus.dz_data;
    if (clr_d) begin
      for (int n = 0; n < IP_LAYER_SIZE; n++) acc_q[n] <= '0;
    end else if ((state_q == MAC) && vld_p1_q) begin
      acc_q[idx_p1_q] <= acc_q[idx_p1_q] + prod_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dz_ready = dz_ready_q;
  assign bus.w_ren    = w_ren_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.dx_valid = dx_valid_q;
  assign bus.dx_data  = dx_valid_q ? acc_q[k_q] : '0;
endmodule
